// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if -- request/response bundle between the EX stage and the mul/div sequencer.
// Revision 1.0
`default_nettype none

`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

interface muldiv_sequencer_if #(
  parameter int W = 64
) ();
  logic         i_valid;
  logic [2:0]   i_funct3;
  logic [W-1:0] i_op_a;
  logic [W-1:0] i_op_b;
  logic         i_flush;
  logic         o_ready;
  logic         o_stall;
  logic         o_valid;
  logic [W-1:0] o_result;

  modport master (
    output i_valid, i_funct3, i_op_a, i_op_b, i_flush,
    input  o_ready, o_stall, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_funct3, i_op_a, i_op_b, i_flush,
    output o_ready, o_stall, o_valid, o_result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- iterative RV M-extension unit: shift-add multiply, restoring divide.
// Revision 1.0
`default_nettype none

`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

module muldiv_sequencer #(
  parameter logic [1:0] XLEN = `XLEN_64b
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int W  = 1 << (XLEN + 4);
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    funct3;
  logic          neg;
  logic [W-1:0]  opnd;
  logic [2*W-1:0] acc;
  logic [W-1:0]  final_res;
  logic [W-1:0]  result;

  logic          accept;
  logic          in_div, in_div_signed, a_signed, b_signed, a_neg, b_neg;
  logic          div_zero, div_ovf, special;
  logic [W-1:0]  a_mag, b_mag, special_res;

  always_comb begin
    accept        = bus.i_valid && (state == IDLE) && !bus.i_flush;
    in_div        = bus.i_funct3[2];
    in_div_signed = in_div && !bus.i_funct3[0];
    a_signed      = in_div ? in_div_signed : (bus.i_funct3 == 3'd1 || bus.i_funct3 == 3'd2);
    b_signed      = in_div ? in_div_signed : (bus.i_funct3 == 3'd1);
    a_neg         = a_signed && bus.i_op_a[W-1];
    b_neg         = b_signed && bus.i_op_b[W-1];
    a_mag         = a_neg ? -bus.i_op_a : bus.i_op_a;
    b_mag         = b_neg ? -bus.i_op_b : bus.i_op_b;
    div_zero      = in_div && (bus.i_op_b == '0);
    div_ovf       = in_div_signed && (bus.i_op_a == MIN_NEG) && (bus.i_op_b == '1);
    special       = div_zero || div_ovf;
    // bit 1 of funct3 selects remainder for REM/REMU
    if (div_zero)
      special_res = bus.i_funct3[1] ? bus.i_op_a : '1;
    else
      special_res = bus.i_funct3[1] ? '0 : bus.i_op_a;
  end

  // One iteration step. acc holds {high, low}: product/multiplier or remainder/quotient.
  logic [W:0]     mul_sum;
  logic [W:0]     partial;
  logic [W-1:0]   sub;
  logic           ge;
  logic [2*W-1:0] acc_next, prod_fix;
  logic [W-1:0]   quo, rem, calc_final;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    partial  = {acc[2*W-1:W], acc[W-1]};
    ge       = partial >= {1'b0, opnd};
    sub      = partial[W-1:0] - opnd;
    if (funct3[2])
      acc_next = ge ? {sub, acc[W-2:0], 1'b1} : {partial[W-1:0], acc[W-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc[W-1:1]};
    prod_fix = neg ? -acc_next : acc_next;
    quo      = acc_next[W-1:0];
    rem      = acc_next[2*W-1:W];
    if (funct3[2])
      calc_final = funct3[1] ? (neg ? -rem : rem) : (neg ? -quo : quo);
    else
      calc_final = (funct3[1:0] == 2'd0) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (bus.i_flush)
          state_nxt = IDLE;
        else if (cnt == '0)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      funct3    <= '0;
      neg       <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      final_res <= '0;
      result    <= '0;
    end else begin
      if (accept) begin
        funct3 <= bus.i_funct3;
        // quotient sign from both operands, remainder sign from dividend
        neg    <= (in_div && bus.i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
        opnd   <= b_mag;
        acc    <= {{W{1'b0}}, a_mag};
        cnt    <= CNT_INIT;
        if (special)
          final_res <= special_res;
      end else if (state == CALC) begin
        acc <= acc_next;
        if (cnt == '0)
          final_res <= calc_final;
        else
          cnt <= cnt - 1'b1;
      end
      if (state == DONE && !bus.i_flush)
        result <= final_res;
    end
  end

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_stall  = (bus.i_valid && state == IDLE) || (state == CALC);
  assign bus.o_valid  = (state == DONE) && !bus.i_flush;
  assign bus.o_result = bus.o_valid ? final_res : result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer -- vector table, corner sequences and random ops against an arithmetic model.
// Revision 1.0
`default_nettype none

`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_sequencer_if #(.W(W)) bus ();

  muldiv_sequencer #(.XLEN(`XLEN_32b)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, pr;
    logic signed [31:0] a32, b32;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    a32 = a;
    b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    pr  = '0;
    case (f3)
      3'd0: begin pr = ua * ub;          return pr[31:0];  end
      3'd1: begin pr = sa * sb;          return pr[63:32]; end
      3'd2: begin pr = sa * $signed(ub); return pr[63:32]; end
      3'd3: begin pr = ua * ub;          return pr[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(a32 / b32);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(a32 % b32);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return W + 1;
  endfunction

  // Starts in an IDLE cycle, just after a rising edge; returns one cycle after o_valid plus two hold cycles.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit stall_ok, output bit post_ok);
    stall_ok = 1'b1;
    post_ok  = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_funct3 = f3;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
    #1;
    if (!(bus.o_stall && bus.o_ready)) stall_ok = 1'b0;
    @(posedge clk); #1;
    bus.i_valid  = 1'b0;
    bus.i_funct3 = 3'($urandom);
    bus.i_op_a   = $urandom;
    bus.i_op_b   = $urandom;
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      if (!bus.o_stall) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.o_result;
    if (bus.o_stall || bus.o_ready) stall_ok = 1'b0;
    @(posedge clk); #1;
    if (bus.o_valid || !bus.o_ready || bus.o_result !== res) post_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (bus.o_valid || bus.o_result !== res) post_ok = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] res, prev, a, b;
    logic [2:0]  f3;
    int          lat, vcount;
    bit          sok, pok;

    vt[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vt[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vt[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vt[5]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vt[6]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vt[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vt[9]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vt[10] = '{3'd4, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};

    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_funct3 = '0;
    bus.i_op_a   = '0;
    bus.i_op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready",  64'(bus.o_ready),  64'd1);
    check("reset_stall",  64'(bus.o_stall),  64'd0);
    check("reset_valid",  64'(bus.o_valid),  64'd0);
    check("reset_result", 64'(bus.o_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].f3, vt[i].a, vt[i].b, res, lat, sok, pok);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vt[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      check($sformatf("vec%0d_stall", i), 64'(sok), 64'd1);
      check($sformatf("vec%0d_hold", i), 64'(pok), 64'd1);
    end

    // flush mid-CALC of a DIVU, then a fresh MUL right away
    prev = bus.o_result;
    bus.i_valid  = 1'b1;
    bus.i_funct3 = 3'd5;
    bus.i_op_a   = 32'd100;
    bus.i_op_b   = 32'd7;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    #1;
    check("flush_calc_valid", 64'(bus.o_valid), 64'd0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_calc_idle", 64'(bus.o_ready), 64'd1);
    check("flush_calc_hold", 64'(bus.o_result), 64'(prev));
    do_op(3'd0, 32'd12345, 32'd6789, res, lat, sok, pok);
    check("after_flush_result",  64'(res), 64'(ref_res(3'd0, 32'd12345, 32'd6789)));
    check("after_flush_latency", 64'(lat), 64'd33);

    // flush in DONE suppresses the strobe and keeps the old result
    prev = bus.o_result;
    bus.i_valid  = 1'b1;
    bus.i_funct3 = 3'd5;
    bus.i_op_a   = 32'd5;
    bus.i_op_b   = 32'd0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b1;
    #1;
    check("flush_done_valid",  64'(bus.o_valid),  64'd0);
    check("flush_done_result", 64'(bus.o_result), 64'(prev));
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_done_idle", 64'(bus.o_ready),  64'd1);
    check("flush_done_hold", 64'(bus.o_result), 64'(prev));

    // flush in IDLE blocks acceptance
    bus.i_valid  = 1'b1;
    bus.i_flush  = 1'b1;
    bus.i_funct3 = 3'd0;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("flush_idle_block", 64'(bus.o_ready), 64'd1);

    // reset asserted in the middle of a MULHSU
    bus.i_valid  = 1'b1;
    bus.i_funct3 = 3'd2;
    bus.i_op_a   = 32'h8765_4321;
    bus.i_op_b   = 32'h1234_5678;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_ready",  64'(bus.o_ready),  64'd1);
    check("midreset_stall",  64'(bus.o_stall),  64'd0);
    check("midreset_valid",  64'(bus.o_valid),  64'd0);
    check("midreset_result", 64'(bus.o_result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid) vcount++;
    end
    check("midreset_no_valid", 64'(vcount), 64'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 300));
        3:       b = -32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      do_op(f3, a, b, res, lat, sok, pok);
      check($sformatf("rand%0d_f%0d_result", i, f3), 64'(res), 64'(ref_res(f3, a, b)));
      check($sformatf("rand%0d_f%0d_latency", i, f3), 64'(lat), 64'(ref_lat(f3, a, b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
